// File: rtl/rf_write_scheduler.sv
// Arbitrates the single register-file write port between WB (priority) and a one-entry MD result buffer,
// tracks outstanding MD destinations in a scoreboard, and raises decode/starvation stalls.
module rf_write_scheduler #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_wn,
  input  logic [31:0] wb_d,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_wn,
  input  logic [31:0] md_d,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wn,
  input  logic        dec_valid,
  input  logic [4:0]  dec_rs,
  input  logic [4:0]  dec_rt,
  input  logic [4:0]  dec_rd,
  output logic        rf_we,
  output logic [4:0]  rf_wn,
  output logic [31:0] rf_d,
  output logic        hazard_stall,
  output logic        starve_stall,
  output logic [31:0] busy_vec
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic              buf_valid_q, buf_valid_d;
  logic [4:0]        buf_wn_q, buf_wn_d;
  logic [31:0]       buf_d_q, buf_d_d;
  logic [31:0]       busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              starve_q, starve_d;

  logic wb_win, drain, buf_free, accept;

  assign md_ready = ~buf_valid_q;
  assign accept   = md_valid & ~buf_valid_q;
  assign wb_win   = wb_we & (wb_wn != 5'd0);
  assign drain    = buf_valid_q & ~wb_win & (buf_wn_q != 5'd0);
  // An r0-targeted result is dropped without ever using the port.
  assign buf_free = buf_valid_q & (drain | (buf_wn_q == 5'd0));

  always_comb begin
    rf_we = 1'b0;
    rf_wn = 5'd0;
    rf_d  = 32'd0;
    if (wb_win) begin
      rf_we = 1'b1;
      rf_wn = wb_wn;
      rf_d  = wb_d;
    end else if (drain) begin
      rf_we = 1'b1;
      rf_wn = buf_wn_q;
      rf_d  = buf_d_q;
    end
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_wn_d    = buf_wn_q;
    buf_d_d     = buf_d_q;
    if (buf_free) buf_valid_d = 1'b0;
    if (accept) begin
      buf_valid_d = 1'b1;
      buf_wn_d    = md_wn;
      buf_d_d     = md_d;
    end
  end

  // Clear before set so an issue to the draining register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (drain) busy_d[buf_wn_q] = 1'b0;
    if (iss_valid && (iss_wn != 5'd0)) busy_d[iss_wn] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!buf_valid_q || buf_free) begin
      cnt_d = '0;
    end else if (cnt_q < LIMIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    starve_d = (cnt_d >= LIMIT) & buf_valid_q & ~drain;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_wn_q    <= 5'd0;
      buf_d_q     <= 32'd0;
      busy_q      <= 32'd0;
      cnt_q       <= '0;
      starve_q    <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_wn_q    <= buf_wn_d;
      buf_d_q     <= buf_d_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
    end
  end

  assign starve_stall = starve_q;
  assign busy_vec     = busy_q;
  assign hazard_stall = starve_q | (dec_valid & (((dec_rs != 5'd0) & busy_q[dec_rs]) |
                                                 ((dec_rt != 5'd0) & busy_q[dec_rt]) |
                                                 ((dec_rd != 5'd0) & busy_q[dec_rd])));

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed scenarios followed by constrained-random traffic, all checked against a queue-based model.
module tb_rf_write_scheduler;
  localparam int LIM = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we, md_valid, iss_valid, dec_valid;
  logic [4:0]  wb_wn, md_wn, iss_wn, dec_rs, dec_rt, dec_rd;
  logic [31:0] wb_d, md_d;
  logic        md_ready, rf_we, hazard_stall, starve_stall;
  logic [4:0]  rf_wn;
  logic [31:0] rf_d, busy_vec;

  always #5 clk = ~clk;

  rf_write_scheduler #(.STARVE_LIMIT(LIM), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_wn(wb_wn), .wb_d(wb_d),
    .md_valid(md_valid), .md_ready(md_ready), .md_wn(md_wn), .md_d(md_d),
    .iss_valid(iss_valid), .iss_wn(iss_wn),
    .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd),
    .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d),
    .hazard_stall(hazard_stall), .starve_stall(starve_stall), .busy_vec(busy_vec)
  );

  typedef struct {logic [4:0] wn; logic [31:0] d;} ent_t;
  ent_t mq[$];
  bit   mbusy[32];
  int   mcnt;
  bit   mstarve;
  bit   last_acc;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] busy_word();
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) w[i] = mbusy[i];
    return w;
  endfunction

  task automatic mreset();
    mq.delete();
    for (int i = 0; i < 32; i++) mbusy[i] = 0;
    mcnt = 0;
    mstarve = 0;
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_wn = 0; wb_d = 0;
    md_valid = 0; md_wn = 0; md_d = 0;
    iss_valid = 0; iss_wn = 0;
    dec_valid = 0; dec_rs = 0; dec_rt = 0; dec_rd = 0;
  endtask

  task automatic check_comb();
    logic        e_we;
    logic [4:0]  e_wn;
    logic [31:0] e_d;
    bit          haz;
    e_we = 0; e_wn = 0; e_d = 0;
    if (wb_we && wb_wn != 0) begin
      e_we = 1; e_wn = wb_wn; e_d = wb_d;
    end else if (mq.size() > 0 && mq[0].wn != 0) begin
      e_we = 1; e_wn = mq[0].wn; e_d = mq[0].d;
    end
    haz = mstarve || (dec_valid && ((dec_rs != 0 && mbusy[dec_rs]) ||
                                    (dec_rt != 0 && mbusy[dec_rt]) ||
                                    (dec_rd != 0 && mbusy[dec_rd])));
    chk("rf_we", 32'(rf_we), 32'(e_we));
    chk("rf_wn", 32'(rf_wn), 32'(e_wn));
    chk("rf_d", rf_d, e_d);
    chk("md_ready", 32'(md_ready), 32'(mq.size() == 0));
    chk("hazard_stall", 32'(hazard_stall), 32'(haz));
    chk("starve_stall", 32'(starve_stall), 32'(mstarve));
    chk("busy_vec", busy_vec, busy_word());
  endtask

  // Check current-cycle outputs, then advance one clock and update the model.
  task automatic cycle();
    bit wb_ok, has, drn, disc, acc;
    ent_t e;
    #1;
    check_comb();
    wb_ok = wb_we && wb_wn != 0;
    has   = mq.size() > 0;
    if (has) e = mq[0];
    drn  = !wb_ok && has && e.wn != 0;
    disc = has && (drn || e.wn == 0);
    acc  = md_valid && !has;
    @(posedge clk);
    if (drn) mbusy[e.wn] = 0;
    if (iss_valid && iss_wn != 0) mbusy[iss_wn] = 1;
    if (!has || disc) mcnt = 0;
    else if (mcnt < LIM) mcnt++;
    mstarve = (mcnt >= LIM) && has && !drn;
    if (disc) void'(mq.pop_front());
    if (acc) mq.push_back('{wn: md_wn, d: md_d});
    last_acc = acc;
    #1;
  endtask

  task automatic issue(input logic [4:0] r);
    iss_valid = 1; iss_wn = r;
    cycle();
    iss_valid = 0; iss_wn = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    mreset();
    #3;
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_md_ready", 32'(md_ready), 32'd1);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_hazard", 32'(hazard_stall), 32'd0);
    #9 rst_n = 1;
    @(posedge clk); #1;

    // Reset mid-operation with r5 buffered and busy.
    issue(5'd5);
    md_valid = 1; md_wn = 5; md_d = 32'h5555; wb_we = 1; wb_wn = 4; wb_d = 32'h44;
    cycle();
    md_valid = 0;
    cycle();
    chk("t1_busy5_pre", 32'(busy_vec[5]), 32'd1);
    idle_inputs();
    rst_n = 0;
    #1;
    mreset();
    chk("t1_busy", busy_vec, 32'd0);
    chk("t1_md_ready", 32'(md_ready), 32'd1);
    chk("t1_rf_we", 32'(rf_we), 32'd0);
    chk("t1_starve", 32'(starve_stall), 32'd0);
    #2 rst_n = 1;
    @(posedge clk); #1;

    // Idle drain.
    issue(5'd8);
    md_valid = 1; md_wn = 8; md_d = 32'hDEADBEEF;
    cycle();
    md_valid = 0;
    #1;
    chk("t2_rf_we", 32'(rf_we), 32'd1);
    chk("t2_rf_wn", 32'(rf_wn), 32'd8);
    chk("t2_rf_d", rf_d, 32'hDEADBEEF);
    chk("t2_busy8_during", 32'(busy_vec[8]), 32'd1);
    cycle();
    chk("t2_busy8_after", 32'(busy_vec[8]), 32'd0);
    chk("t2_md_ready", 32'(md_ready), 32'd1);

    // WB conflict, then an r0 WB lets the buffer drain.
    issue(5'd9);
    md_valid = 1; md_wn = 9; md_d = 32'h99; wb_we = 1; wb_wn = 3; wb_d = 32'h33;
    cycle();
    md_valid = 0;
    #1 chk("t3_wn_a", 32'(rf_wn), 32'd3);
    cycle();
    #1 chk("t3_wn_b", 32'(rf_wn), 32'd3);
    cycle();
    wb_wn = 0;
    #1 chk("t3_wn_c", 32'(rf_wn), 32'd9);
    chk("t3_d_c", rf_d, 32'h99);
    cycle();
    chk("t3_empty", 32'(md_ready), 32'd1);
    idle_inputs();

    // RAW/WAW decode stall.
    issue(5'd12);
    dec_valid = 1; dec_rs = 12;
    #1 chk("t4_rs", 32'(hazard_stall), 32'd1);
    dec_rs = 0; dec_rd = 12;
    #1 chk("t4_rd", 32'(hazard_stall), 32'd1);
    dec_rd = 0; dec_rt = 13;
    #1 chk("t4_none", 32'(hazard_stall), 32'd0);
    dec_rt = 0; dec_rs = 12;
    md_valid = 1; md_wn = 12; md_d = 32'h1212;
    cycle();
    md_valid = 0;
    #1 chk("t4_draining", 32'(hazard_stall), 32'd1);
    cycle();
    #1 chk("t4_released", 32'(hazard_stall), 32'd0);
    idle_inputs();

    // Starvation: WB to r4 every cycle while r10 waits.
    issue(5'd10);
    md_valid = 1; md_wn = 10; md_d = 32'hA0A0; wb_we = 1; wb_wn = 4; wb_d = 32'h4;
    cycle();
    md_valid = 0;
    for (int k = 1; k <= LIM; k++) begin
      cycle();
      chk($sformatf("t5_starve_%0d", k), 32'(starve_stall), 32'(k == LIM));
    end
    wb_we = 0;
    #1 chk("t5_hazard_starve", 32'(hazard_stall), 32'd1);
    chk("t5_drain_wn", 32'(rf_wn), 32'd10);
    cycle();
    chk("t5_starve_off", 32'(starve_stall), 32'd0);
    chk("t5_md_ready", 32'(md_ready), 32'd1);
    idle_inputs();

    // Issue and drain of r7 in the same cycle keeps it busy.
    issue(5'd7);
    md_valid = 1; md_wn = 7; md_d = 32'h77;
    cycle();
    md_valid = 0; iss_valid = 1; iss_wn = 7;
    cycle();
    iss_valid = 0;
    chk("t6_busy7", 32'(busy_vec[7]), 32'd1);

    // Back-to-back MD results with WB idle.
    md_valid = 1; md_wn = 20; md_d = 32'h2000;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("t6_ready_%0d", k), 32'(md_ready), 32'((k % 2) == 0));
      cycle();
      if (last_acc) begin md_wn = md_wn + 1; md_d = md_d + 1; end
    end
    idle_inputs();
    cycle();

    // Random traffic under the pipeline and MD contracts.
    for (int n = 0; n < 600; n++) begin
      if (!md_valid && $urandom_range(2) == 0) begin
        md_valid = 1;
        md_wn = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
        md_d  = $urandom;
      end
      wb_we = mstarve ? 1'b0 : 1'($urandom_range(3) != 0);
      wb_wn = ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom_range(31));
      wb_d  = $urandom;
      iss_valid = 1'($urandom_range(3) == 0);
      iss_wn    = 5'($urandom_range(31));
      dec_valid = 1'($urandom);
      dec_rs = 5'($urandom_range(31));
      dec_rt = 5'($urandom_range(31));
      dec_rd = ($urandom_range(2) == 0) ? 5'd0 : 5'($urandom_range(31));
      cycle();
      if (last_acc) md_valid = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
